// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and the linear address helper, also used by the
// VGA scan-out address generator.
package fb_pkg;
  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int FB_ADDR_W = 17;
  localparam int COLOR_W   = 3;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int PIX_W     = FB_ADDR_W + COLOR_W;

  // y*320 + x built from two shifts so no multiplier is inferred.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] px,
                                                   input logic [Y_W-1:0] py);
    logic [FB_ADDR_W-1:0] yw;
    logic [FB_ADDR_W-1:0] xw;
    yw = {{(FB_ADDR_W-Y_W){1'b0}}, py};
    xw = {{(FB_ADDR_W-X_W){1'b0}}, px};
    return (yw << 8) + (yw << 6) + xw;
  endfunction
endpackage

// File: rtl/framebuffer_writer_fifo.sv
// Small pixel FIFO; a push into a full FIFO is legal when a pop happens in the
// same cycle. Occupancy is tracked separately from the wrapping pointers.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Storage is cleared on reset so the write port reads zero afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/framebuffer_writer.sv
// Plot-strobe sink: registers the pixel, range-checks it, converts to a linear
// address and queues it for the framebuffer write port with back-pressure.
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 plot,
  input  logic [X_W-1:0]       x,
  input  logic [Y_W-1:0]       y,
  input  logic [COLOR_W-1:0]   color,
  output logic                 busy,
  output logic                 idle,
  output logic                 mem_we,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic [COLOR_W-1:0]   mem_data,
  input  logic                 mem_ready,
  output logic [7:0]           dropped_count
);
  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  logic                 vld_p1;
  logic [X_W-1:0]       x_p1;
  logic [Y_W-1:0]       y_p1;
  logic [COLOR_W-1:0]   color_p1;
  logic [FB_ADDR_W-1:0] addr_p1;
  logic                 in_range;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic [PIX_W-1:0]     head;

  // Stage 1: input register; data captured every cycle, only valid is reset
  always_ff @(posedge clock) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= plot;
  end

  always_ff @(posedge clock) begin
    x_p1     <= x;
    y_p1     <= y;
    color_p1 <= color;
  end

  assign in_range = (x_p1 < X_LIM) && (y_p1 < Y_LIM);
  assign addr_p1  = fb_addr(x_p1, y_p1);
  assign pop      = mem_we && mem_ready;
  assign push     = vld_p1 && in_range && (!full || pop);
  assign drop     = vld_p1 && (!in_range || (full && !pop));

  // Stage 2: FIFO feeding the framebuffer write port
  pixel_fifo #(.DEPTH(DEPTH), .WIDTH(PIX_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data ({addr_p1, color_p1}),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_ff @(posedge clock) begin
    if (reset)                              dropped_count <= '0;
    else if (drop && dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
  end

  assign mem_we   = !empty;
  assign mem_addr = head[PIX_W-1:COLOR_W];
  assign mem_data = head[COLOR_W-1:0];
  assign busy     = full;
  assign idle     = !vld_p1 && empty;
endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: directed scenarios plus randomized traffic
// checked against a transaction-level queue model.
module tb_framebuffer_writer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        plot;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  color;
  logic        busy;
  logic        idle;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_ready;
  logic [7:0]  dropped_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: staged pixel, queued writes, drop count; writes observed/expected
  bit m_sv;
  int m_sx, m_sy, m_sc;
  int mq[$];
  int m_drop;
  int act[$];
  int exp_q[$];

  always #5 clock = ~clock;

  framebuffer_writer #(.DEPTH(DEPTH), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .clock         (clock),
    .reset         (reset),
    .plot          (plot),
    .x             (x),
    .y             (y),
    .color         (color),
    .busy          (busy),
    .idle          (idle),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .dropped_count (dropped_count)
  );

  function automatic int enc(input int px, input int py, input int pc);
    return (py * 320 + px) * 8 + pc;
  endfunction

  task automatic step(input bit p, input int px, input int py, input int pc, input bit r);
    plot = p; x = px[8:0]; y = py[7:0]; color = pc[2:0]; mem_ready = r;
    if (mem_we && mem_ready) act.push_back(int'(mem_addr) * 8 + int'(mem_data));
    if (mq.size() > 0 && r) exp_q.push_back(mq.pop_front());
    if (m_sv) begin
      if (m_sx < 320 && m_sy < 240 && mq.size() < DEPTH) mq.push_back(enc(m_sx, m_sy, m_sc));
      else if (m_drop < 255) m_drop++;
    end
    m_sv = p; m_sx = px & 511; m_sy = py & 255; m_sc = pc & 7;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; plot = 1'b0; mem_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_sv = 0; mq.delete(); m_drop = 0;
    act.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0d want 0", mem_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d want 0", busy); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0d want 1", idle); end
    n_checks++; if (dropped_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", dropped_count); end
    n_checks++; if (mem_addr !== 17'd0 || mem_data !== 3'd0) begin n_fail++; $display("FAIL reset_head: got %0d/%0d want 0/0", mem_addr, mem_data); end
  endtask

  task automatic test_single();
    do_reset();
    step(1, 5, 2, 5, 1);
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_early: got we=%0d want 0", mem_we); end
    step(0, 0, 0, 0, 1);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 17'd645 || mem_data !== 3'd5) begin
      n_fail++; $display("FAIL single_write: got we=%0d addr=%0d data=%0d want 1/645/5", mem_we, mem_addr, mem_data); end
    step(0, 0, 0, 0, 1);
    n_checks++; if (mem_we !== 1'b0 || act.size() != 1) begin
      n_fail++; $display("FAIL single_once: got we=%0d writes=%0d want 0/1", mem_we, act.size()); end
  endtask

  task automatic test_corners();
    do_reset();
    step(1, 319, 239, 2, 1);
    step(1, 0, 0, 6, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    n_checks++; if (act.size() != 2) begin n_fail++; $display("FAIL corner_count: got %0d want 2", act.size()); end
    else begin
      n_checks++; if (act[0] != 76799 * 8 + 2) begin n_fail++; $display("FAIL corner_max: got %0d want %0d", act[0] / 8, 76799); end
      n_checks++; if (act[1] != 6) begin n_fail++; $display("FAIL corner_zero: got %0d want 0", act[1] / 8); end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    step(1, 320, 0, 1, 1);
    step(1, 0, 240, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    n_checks++; if (act.size() != 0) begin n_fail++; $display("FAIL oor_writes: got %0d want 0", act.size()); end
    n_checks++; if (dropped_count !== 8'd2) begin n_fail++; $display("FAIL oor_drop: got %0d want 2", dropped_count); end
  endtask

  task automatic test_stall();
    int pix[6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      int px, py, pc;
      px = $urandom_range(319); py = $urandom_range(239); pc = $urandom_range(7);
      pix[i] = enc(px, py, pc);
      step(1, px, py, pc, 0);
    end
    step(0, 0, 0, 0, 0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %0d want 1", busy); end
    n_checks++; if (dropped_count !== 8'd2) begin n_fail++; $display("FAIL stall_drop: got %0d want 2", dropped_count); end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    n_checks++; if (act.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", act.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (act[i] != pix[i]) begin n_fail++; $display("FAIL stall_order%0d: got %0d want %0d", i, act[i], pix[i]); end
    end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL stall_idle: got %0d want 1", idle); end
  endtask

  task automatic test_full_pop();
    int pix[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      int px, py, pc;
      px = $urandom_range(319); py = $urandom_range(239); pc = $urandom_range(7);
      pix[i] = enc(px, py, pc);
      step(1, px, py, pc, 0);
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fullpop_pre: got busy=%0d want 1", busy); end
    step(0, 0, 0, 0, 1);
    n_checks++; if (busy !== 1'b1 || dropped_count !== 8'd0 || act.size() != 1) begin
      n_fail++; $display("FAIL fullpop_same: got busy=%0d drop=%0d writes=%0d want 1/0/1", busy, dropped_count, act.size()); end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    n_checks++; if (act.size() != 5) begin n_fail++; $display("FAIL fullpop_count: got %0d want 5", act.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_checks++; if (act[i] != pix[i]) begin n_fail++; $display("FAIL fullpop_order%0d: got %0d want %0d", i, act[i], pix[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int pix[$];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      int px, py, pc;
      px = $urandom_range(319); py = $urandom_range(239); pc = $urandom_range(7);
      if (i == 7) begin px = m_sx; py = m_sy; end
      pix.push_back(enc(px, py, pc));
      step(1, px, py, pc, 1);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy%0d: got %0d want 0", i, busy); end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    n_checks++; if (act.size() != 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", act.size()); end
    else for (int i = 0; i < 20; i++) begin
      n_checks++; if (act[i] != pix[i]) begin n_fail++; $display("FAIL b2b_order%0d: got %0d want %0d", i, act[i], pix[i]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(9) < 7, $urandom_range(335), $urandom_range(250),
           $urandom_range(7), $urandom_range(9) < 6);
      n_checks++; if (mem_we !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_we@%0d: got %0d want %0d", i, mem_we, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_checks++; if (int'(mem_addr) * 8 + int'(mem_data) != mq[0]) begin
          n_fail++; $display("FAIL rnd_head@%0d: got %0d want %0d", i, int'(mem_addr) * 8 + int'(mem_data), mq[0]); end
      end
      n_checks++; if (busy !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %0d want %0d", i, busy, mq.size() == DEPTH); end
      n_checks++; if (idle !== (!m_sv && mq.size() == 0)) begin n_fail++; $display("FAIL rnd_idle@%0d: got %0d", i, idle); end
      n_checks++; if (int'(dropped_count) != m_drop) begin n_fail++; $display("FAIL rnd_drop@%0d: got %0d want %0d", i, dropped_count, m_drop); end
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    n_checks++; if (act.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_writes: got %0d want %0d", act.size(), exp_q.size()); end
    else for (int i = 0; i < act.size(); i++) begin
      n_checks++; if (act[i] != exp_q[i]) begin n_fail++; $display("FAIL rnd_write%0d: got %0d want %0d", i, act[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_saturation();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 10 + i, 20, 3, 0);
    step(0, 0, 0, 0, 0);
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we: got %0d want 1", mem_we); end
    do_reset();
    n_checks++; if (mem_we !== 1'b0 || idle !== 1'b1 || dropped_count !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid: got we=%0d idle=%0d drop=%0d want 0/1/0", mem_we, idle, dropped_count); end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    n_checks++; if (act.size() != 0) begin n_fail++; $display("FAIL rst_discard: got %0d writes want 0", act.size()); end
    for (int i = 0; i < 300; i++) step(1, 400, $urandom_range(255), 1, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1);
    n_checks++; if (dropped_count !== 8'd255) begin n_fail++; $display("FAIL sat_drop: got %0d want 255", dropped_count); end
  endtask

  initial begin
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; color = '0; mem_ready = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_corners();
    test_out_of_range();
    test_stall();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_reset_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
